// File: rtl/hbridge_output_guard.sv
// rtl/hbridge_output_guard.sv - dead-time, shoot-through and watchdog guard for two H-bridge channels (optional watchdog: HB_WATCHDOG_EN)
module hbridge_output_guard #(
    parameter int DEADTIME   = 2000,
    parameter int WDT_CYCLES = 5000000
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic [1:0] motor1_ctrl_in,
    input  logic       motor1_pwm_in,
    input  logic [1:0] motor2_ctrl_in,
    input  logic       motor2_pwm_in,
    input  logic       wdt_kick,
    output logic [1:0] motor1_ctrl,
    output logic       motor1_pwm,
    output logic [1:0] motor2_ctrl,
    output logic       motor2_pwm,
    output logic       motor1_dead,
    output logic       motor2_dead,
    output logic [1:0] shoot_thru_err,
    output logic       wdt_expired
);

    localparam int CW = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEADTIME - 1);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    localparam logic [1:0] CTRL_COAST   = 2'b00;
    localparam logic [1:0] CTRL_ILLEGAL = 2'b11;

    // Per-channel views of the ports so both channels share one body.
    logic [1:0] ctrl_in_a  [2];
    logic       pwm_in_a   [2];
    logic [1:0] ctrl_out_a [2];
    logic       pwm_out_a  [2];
    logic       dead_out_a [2];
    logic       err_out_a  [2];

    // Forces both channels to coast; only ever asserted by the watchdog.
    logic       wdt_force;

    assign ctrl_in_a[0] = motor1_ctrl_in;
    assign ctrl_in_a[1] = motor2_ctrl_in;
    assign pwm_in_a[0]  = motor1_pwm_in;
    assign pwm_in_a[1]  = motor2_pwm_in;

    assign motor1_ctrl    = ctrl_out_a[0];
    assign motor2_ctrl    = ctrl_out_a[1];
    assign motor1_pwm     = pwm_out_a[0];
    assign motor2_pwm     = pwm_out_a[1];
    assign motor1_dead    = dead_out_a[0];
    assign motor2_dead    = dead_out_a[1];
    assign shoot_thru_err = {err_out_a[1], err_out_a[0]};

`ifdef HB_WATCHDOG_EN
    logic [31:0] wdt_cnt;
    logic        wdt_q;

    // The trip is computed combinationally so the channels coast in the same
    // cycle wdt_expired rises; a kick always overrides the trip.
    assign wdt_force   = !wdt_kick && (wdt_q || (wdt_cnt == 32'(WDT_CYCLES - 1)));
    assign wdt_expired = wdt_q;

    // Free-running kick counter; holds once tripped so it can never wrap.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else if (wdt_kick) begin
            wdt_cnt <= '0;
            wdt_q   <= 1'b0;
        end else begin
            wdt_q <= wdt_force;
            if (!wdt_force) begin
                wdt_cnt <= wdt_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_wdt;

    assign wdt_force   = 1'b0;
    assign wdt_expired = 1'b0;
    assign unused_wdt  = wdt_kick ^ (WDT_CYCLES < 1);
`endif

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_chan
            logic [0:0]    state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [1:0]    drv_q, drv_d;
            logic          pwm_q, pwm_d;
            logic          err_q;
            logic [1:0]    san;
            logic          reversal;

            // 11 would short the bridge; treat it as coast.
            assign san = (ctrl_in_a[g] == CTRL_ILLEGAL) ? CTRL_COAST : ctrl_in_a[g];

            // A reversal is a direct fwd<->rev swap; anything through coast is safe.
            assign reversal = ((drv_q == 2'b01) || (drv_q == 2'b10)) &&
                              ((san == 2'b01) || (san == 2'b10)) &&
                              (san != drv_q);

            // Next-state and next-output selection for this channel.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                drv_d   = drv_q;
                pwm_d   = pwm_q;
                if (wdt_force) begin
                    state_d = ST_PASS;
                    cnt_d   = '0;
                    drv_d   = CTRL_COAST;
                    pwm_d   = 1'b0;
                end else if (state_q == ST_PASS) begin
                    if (reversal) begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LOAD;
                        drv_d   = CTRL_COAST;
                        pwm_d   = 1'b0;
                    end else begin
                        drv_d = san;
                        pwm_d = pwm_in_a[g] && (san != CTRL_COAST);
                    end
                end else begin
                    // Leaving DEAD the driven ctrl is coast, so whatever the
                    // input is now can go straight to the pins.
                    if (cnt_q == '0) begin
                        state_d = ST_PASS;
                        drv_d   = san;
                        pwm_d   = pwm_in_a[g] && (san != CTRL_COAST);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        drv_d = CTRL_COAST;
                        pwm_d = 1'b0;
                    end
                end
            end

            // Channel registers; everything on the pins comes straight from here.
            always_ff @(posedge PCLK or negedge PRESERN) begin
                if (!PRESERN) begin
                    state_q <= ST_PASS;
                    cnt_q   <= '0;
                    drv_q   <= CTRL_COAST;
                    pwm_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    drv_q   <= drv_d;
                    pwm_q   <= pwm_d;
                end
            end

            // Sticky record of any illegal code, seen in any state.
            always_ff @(posedge PCLK or negedge PRESERN) begin
                if (!PRESERN) begin
                    err_q <= 1'b0;
                end else if (ctrl_in_a[g] == CTRL_ILLEGAL) begin
                    err_q <= 1'b1;
                end
            end

            assign ctrl_out_a[g] = drv_q;
            assign pwm_out_a[g]  = pwm_q;
            assign dead_out_a[g] = (state_q == ST_DEAD);
            assign err_out_a[g]  = err_q;
        end
    endgenerate

endmodule
